rng_round_controller: RTL and testbench

Sequencer for the RNG datapath (RNG generator plus four load registers). On a start request it pulses the RNG load strobe and captures the three registered random numbers and the key. It rejects and re-rolls rounds that contain duplicate values, then presents the four values one at a time to the game logic over a valid/ack handshake. It runs a configurable number of rounds per game and then reports done.

---
 rtl/rng_round_controller_if.sv | 55 +++++
 rtl/rng_round_controller.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_rng_round_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_round_controller_if.sv
// ---------------------------------------------------------------------------
// rng_round_controller_if
//
// Purpose:
//   Groups the signals between the round controller, the RNG load registers
//   and the game-logic consumer into one bundle.
//
// Signals:
//   rng_1_in..rng_3_in  registered RNG values from the load registers
//   key_in              registered key from the load registers
//   load                one-cycle strobe telling the load registers to load
//   num_out             value currently presented to the consumer
//   num_idx             index of that value (0..2 = rng_1..3, 3 = key)
//   num_valid           num_out/num_idx are valid
//   ack                 consumer accepted the presented value
//
// Modports:
//   master  the round controller side
//   slave   the RNG registers / consumer side (used by the testbench)
// ---------------------------------------------------------------------------
interface rng_round_controller_if;
  logic [3:0] rng_1_in;
  logic [3:0] rng_2_in;
  logic [3:0] rng_3_in;
  logic [3:0] key_in;
  logic       load;
  logic [3:0] num_out;
  logic [1:0] num_idx;
  logic       num_valid;
  logic       ack;

  modport master (
    input  rng_1_in,
    input  rng_2_in,
    input  rng_3_in,
    input  key_in,
    input  ack,
    output load,
    output num_out,
    output num_idx,
    output num_valid
  );

  modport slave (
    output rng_1_in,
    output rng_2_in,
    output rng_3_in,
    output key_in,
    output ack,
    input  load,
    input  num_out,
    input  num_idx,
    input  num_valid
  );
endinterface

// File: rtl/rng_round_controller.sv
// ---------------------------------------------------------------------------
// rng_round_controller
//
// Purpose:
//   Sequences the RNG datapath for one game. Each round pulses the RNG load
//   strobe, captures the three random values and the key, re-rolls rounds
//   that contain duplicates (up to MAX_RETRY times), then hands the four
//   values to the game logic one at a time over a valid/ack handshake.
//   After ROUNDS rounds the controller reports done.
//
// Parameters:
//   ROUNDS     rounds per game (1 .. 2^ROUND_W-1)
//   ROUND_W    width of the round counter
//   MAX_RETRY  re-rolls allowed per round before retry_err is flagged
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      begin a game (honoured only in IDLE or DONE)
//   abort      synchronous abort, returns to IDLE on the next edge
//   bus        controller side of rng_round_controller_if
//   busy       high in every state except IDLE and DONE
//   done       game finished, held until the next start or abort
//   retry_err  sticky, some round exhausted its re-rolls; cleared on start
//   round_cnt  rounds completed in the current game (saturates at ROUNDS)
// ---------------------------------------------------------------------------
module rng_round_controller #(
  parameter int ROUNDS    = 4,
  parameter int ROUND_W   = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  rng_round_controller_if.master    bus,
  output logic                      busy,
  output logic                      done,
  output logic                      retry_err,
  output logic [ROUND_W-1:0]        round_cnt
);

  // A zero-retry configuration still needs a one-bit counter.
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [ROUND_W-1:0] ROUNDS_V    = ROUND_W'(ROUNDS);
  localparam logic [RETRY_W-1:0] MAX_RETRY_V = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CHECK,
    PRESENT,
    ROUND_END,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Captured copies of the load registers for the round in progress.
  logic [3:0] cap_rng_1;
  logic [3:0] cap_rng_2;
  logic [3:0] cap_rng_3;
  logic [3:0] cap_key;

  logic [1:0]         idx;
  logic [RETRY_W-1:0] retry_cnt;
  logic [ROUND_W-1:0] round_next;

  logic dup;
  logic retry_exhausted;

  // Datapath strobes produced by the next-state logic.
  logic clear_game;
  logic capture;
  logic retry_inc;
  logic retry_clr;
  logic err_set;
  logic idx_clr;
  logic idx_inc;
  logic round_inc;

  // Registered-state-derived outputs.
  logic       load_o;
  logic       num_valid_o;
  logic [3:0] num_out_o;
  logic [1:0] num_idx_o;

  // A round is rejected if any two of the four captured values match.
  assign dup = (cap_rng_1 == cap_rng_2) || (cap_rng_1 == cap_rng_3) ||
               (cap_rng_1 == cap_key)   || (cap_rng_2 == cap_rng_3) ||
               (cap_rng_2 == cap_key)   || (cap_rng_3 == cap_key);

  assign retry_exhausted = (retry_cnt >= MAX_RETRY_V);

  // Saturating increment so the round counter can never wrap.
  assign round_next = (round_cnt == ROUNDS_V) ? round_cnt : round_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. abort is checked before the state case so
  // it overrides every other event and suppresses all datapath strobes.
  always_comb begin
    next_state  = state;
    clear_game  = 1'b0;
    capture     = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    err_set     = 1'b0;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    round_inc   = 1'b0;

    load_o      = (state == LOAD);
    num_valid_o = (state == PRESENT);
    busy        = (state != IDLE) && (state != DONE);
    done        = (state == DONE);

    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = LOAD;
            clear_game = 1'b1;
          end
        end
        LOAD: begin
          next_state = WAIT;
        end
        WAIT: begin
          // The load registers were updated on the edge that entered WAIT.
          next_state = CHECK;
          capture    = 1'b1;
        end
        CHECK: begin
          if (dup && !retry_exhausted) begin
            next_state = LOAD;
            retry_inc  = 1'b1;
          end else begin
            // Out of re-rolls: flag it, but still present what was captured.
            err_set    = dup;
            idx_clr    = 1'b1;
            next_state = PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            if (idx == 2'd3) begin
              next_state = ROUND_END;
            end else begin
              idx_inc = 1'b1;
            end
          end
        end
        ROUND_END: begin
          round_inc = 1'b1;
          retry_clr = 1'b1;
          if (round_next == ROUNDS_V) begin
            next_state = DONE;
          end else begin
            next_state = LOAD;
          end
        end
        DONE: begin
          if (start) begin
            next_state = LOAD;
            clear_game = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Presented value, forced to zero whenever nothing is being presented.
  always_comb begin
    num_out_o = 4'd0;
    num_idx_o = 2'd0;
    if (num_valid_o) begin
      num_idx_o = idx;
      case (idx)
        2'd0:    num_out_o = cap_rng_1;
        2'd1:    num_out_o = cap_rng_2;
        2'd2:    num_out_o = cap_rng_3;
        default: num_out_o = cap_key;
      endcase
    end
  end

  assign bus.load      = load_o;
  assign bus.num_valid = num_valid_o;
  assign bus.num_out   = num_out_o;
  assign bus.num_idx   = num_idx_o;

  // Capture of the four load-register values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_rng_1 <= 4'd0;
      cap_rng_2 <= 4'd0;
      cap_rng_3 <= 4'd0;
      cap_key   <= 4'd0;
    end else if (capture) begin
      cap_rng_1 <= bus.rng_1_in;
      cap_rng_2 <= bus.rng_2_in;
      cap_rng_3 <= bus.rng_3_in;
      cap_key   <= bus.key_in;
    end
  end

  // Re-roll counter; restarts at every game start and at every round end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_cnt <= '0;
    end else if (clear_game || retry_clr) begin
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Sticky retry error. abort leaves it alone so it can be inspected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_err <= 1'b0;
    end else if (clear_game) begin
      retry_err <= 1'b0;
    end else if (err_set) begin
      retry_err <= 1'b1;
    end
  end

  // Presentation index. Cleared on abort so a later game always starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= 2'd0;
    end else if (abort || clear_game || idx_clr) begin
      idx <= 2'd0;
    end else if (idx_inc) begin
      idx <= idx + 2'd1;
    end
  end

  // Completed-round counter, held through DONE and abort until next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_cnt <= '0;
    end else if (clear_game) begin
      round_cnt <= '0;
    end else if (round_inc) begin
      round_cnt <= round_next;
    end
  end

  // Structural invariants of the sequencer.
  a_load_single: assert property (@(posedge clk) disable iff (!rst)
    load_o |=> !load_o);

  a_round_cap: assert property (@(posedge clk) disable iff (!rst)
    round_cnt <= ROUNDS_V);

  a_present_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == PRESENT && !bus.ack && !abort) |=>
      (num_valid_o && $stable(num_out_o) && $stable(num_idx_o)));

  a_busy_done: assert property (@(posedge clk) disable iff (!rst)
    !(busy && done));

endmodule

// File: tb/tb_rng_round_controller.sv
// ---------------------------------------------------------------------------
// tb_rng_round_controller
//
// Purpose:
//   Self-checking bench for rng_round_controller. Two instances are used:
//   dut1 runs one round per game, dut4 runs four. dut1 is fed by a model of
//   the RNG load registers that takes a new value set on each load strobe;
//   dut4 sees constant inputs. Expected presented values are queued when a
//   game is started and popped by per-instance monitors on every accepted
//   transfer.
// ---------------------------------------------------------------------------
module tb_rng_round_controller;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] val;
  } exp_t;

  logic clk;
  logic rst;
  logic start1;
  logic abort1;
  logic start4;
  logic abort4;

  logic       busy1;
  logic       done1;
  logic       retry_err1;
  logic [2:0] round_cnt1;
  logic       busy4;
  logic       done4;
  logic       retry_err4;
  logic [2:0] round_cnt4;

  int checks;
  int failures;
  int cyc;
  int load_cnt1;
  int prev_load_cyc;
  int last_load_cyc;

  exp_t        exp1_q[$];
  exp_t        exp4_q[$];
  logic [15:0] set_q[$];
  logic [15:0] default_set;
  logic [15:0] next_set;

  rng_round_controller_if bus1 ();
  rng_round_controller_if bus4 ();

  rng_round_controller #(.ROUNDS(1), .ROUND_W(3), .MAX_RETRY(3)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .abort     (abort1),
    .bus       (bus1),
    .busy      (busy1),
    .done      (done1),
    .retry_err (retry_err1),
    .round_cnt (round_cnt1)
  );

  rng_round_controller #(.ROUNDS(4), .ROUND_W(3), .MAX_RETRY(3)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .abort     (abort4),
    .bus       (bus4),
    .busy      (busy4),
    .done      (done4),
    .retry_err (retry_err4),
    .round_cnt (round_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Load-register model for dut1: on a load strobe take the next queued set,
  // or the default set when the queue is empty. Also counts load pulses.
  always @(posedge clk) begin
    if (bus1.load) begin
      if (set_q.size() > 0) next_set = set_q.pop_front();
      else next_set = default_set;
      bus1.rng_1_in <= next_set[15:12];
      bus1.rng_2_in <= next_set[11:8];
      bus1.rng_3_in <= next_set[7:4];
      bus1.key_in   <= next_set[3:0];
      load_cnt1     <= load_cnt1 + 1;
      prev_load_cyc <= last_load_cyc;
      last_load_cyc <= cyc;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitors: every accepted transfer must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus1.num_valid && bus1.ack) begin
      if (exp1_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut1_unexpected: actual idx=%0d val=0x%0h expected none",
                 bus1.num_idx, bus1.num_out);
      end else begin
        e = exp1_q.pop_front();
        check_output("dut1_idx", 32'(bus1.num_idx), 32'(e.idx));
        check_output("dut1_val", 32'(bus1.num_out), 32'(e.val));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus4.num_valid && bus4.ack) begin
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL dut4_unexpected: actual idx=%0d val=0x%0h expected none",
                 bus4.num_idx, bus4.num_out);
      end else begin
        e = exp4_q.pop_front();
        check_output("dut4_idx", 32'(bus4.num_idx), 32'(e.idx));
        check_output("dut4_val", 32'(bus4.num_out), 32'(e.val));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue the four values (rng_1, rng_2, rng_3, key) expected for a round.
  task automatic push_exp(input int sel, input logic [15:0] set);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.idx = 2'(k);
      e.val = set[15-4*k -: 4];
      if (sel == 1) exp1_q.push_back(e);
      else exp4_q.push_back(e);
    end
  endtask

  // One-cycle start pulse; returns #1 after the edge that sampled it.
  task automatic apply_stimulus(input int sel);
    if (sel == 1) start1 = 1'b1;
    else start4 = 1'b1;
    tick(1);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input string name);
    for (int i = 0; i < 300; i++) begin
      if ((sel == 1 && done1) || (sel == 4 && done4)) break;
      tick(1);
    end
    check_output(name, 32'(sel == 1 ? done1 : done4), 32'd1);
  endtask

  task automatic wait_valid1(input string name);
    for (int i = 0; i < 40; i++) begin
      if (bus1.num_valid) break;
      tick(1);
    end
    check_output(name, 32'(bus1.num_valid), 32'd1);
  endtask

  task automatic check_all_zero1(input string tag);
    check_output({tag, "_load"},      32'(bus1.load),      32'd0);
    check_output({tag, "_num_valid"}, 32'(bus1.num_valid), 32'd0);
    check_output({tag, "_num_out"},   32'(bus1.num_out),   32'd0);
    check_output({tag, "_num_idx"},   32'(bus1.num_idx),   32'd0);
    check_output({tag, "_busy"},      32'(busy1),          32'd0);
    check_output({tag, "_done"},      32'(done1),          32'd0);
    check_output({tag, "_retry_err"}, 32'(retry_err1),     32'd0);
    check_output({tag, "_round_cnt"}, 32'(round_cnt1),     32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int found;
    checks = 0;
    failures = 0;
    cyc = 0;
    load_cnt1 = 0;
    prev_load_cyc = 0;
    last_load_cyc = 0;
    rst = 1'b0;
    start1 = 1'b0;
    abort1 = 1'b0;
    start4 = 1'b0;
    abort4 = 1'b0;
    bus1.ack = 1'b0;
    bus4.ack = 1'b0;
    bus4.rng_1_in = 4'd1;
    bus4.rng_2_in = 4'd2;
    bus4.rng_3_in = 4'd3;
    bus4.key_in   = 4'd4;
    default_set = 16'h379C;

    // Reset state.
    #12;
    check_all_zero1("reset");
    tick(1);
    rst = 1'b1;
    tick(2);

    // Clean round, cycle-exact latency.
    $display("[TB] clean round");
    bus1.ack = 1'b1;
    push_exp(1, 16'h379C);
    base = load_cnt1;
    apply_stimulus(1);
    check_output("clean_load_c1", 32'(bus1.load), 32'd1);
    check_output("clean_busy_c1", 32'(busy1), 32'd1);
    tick(1);
    check_output("clean_load_c2", 32'(bus1.load), 32'd0);
    tick(1);
    check_output("clean_valid_c3", 32'(bus1.num_valid), 32'd0);
    check_output("clean_load_c3", 32'(bus1.load), 32'd0);
    tick(1);
    check_output("clean_valid_c4", 32'(bus1.num_valid), 32'd1);
    check_output("clean_idx_c4", 32'(bus1.num_idx), 32'd0);
    check_output("clean_out_c4", 32'(bus1.num_out), 32'd3);
    tick(3);
    check_output("clean_idx_c7", 32'(bus1.num_idx), 32'd3);
    check_output("clean_out_c7", 32'(bus1.num_out), 32'd12);
    tick(1);
    check_output("clean_valid_c8", 32'(bus1.num_valid), 32'd0);
    check_output("clean_done_c8", 32'(done1), 32'd0);
    tick(1);
    check_output("clean_done_c9", 32'(done1), 32'd1);
    check_output("clean_round_cnt", 32'(round_cnt1), 32'd1);
    check_output("clean_busy_c9", 32'(busy1), 32'd0);
    check_output("clean_loads", 32'(load_cnt1 - base), 32'd1);

    // Duplicate re-roll.
    $display("[TB] duplicate re-roll");
    set_q.push_back(16'h5528);
    set_q.push_back(16'h1468);
    push_exp(1, 16'h1468);
    base = load_cnt1;
    apply_stimulus(1);
    wait_done(1, "dup_done");
    check_output("dup_loads", 32'(load_cnt1 - base), 32'd2);
    check_output("dup_spacing", 32'(last_load_cyc - prev_load_cyc), 32'd3);
    check_output("dup_retry_err", 32'(retry_err1), 32'd0);
    check_output("dup_round_cnt", 32'(round_cnt1), 32'd1);

    // Retry exhaustion.
    $display("[TB] retry exhaustion");
    default_set = 16'h2222;
    push_exp(1, 16'h2222);
    base = load_cnt1;
    apply_stimulus(1);
    wait_done(1, "exh_done");
    check_output("exh_loads", 32'(load_cnt1 - base), 32'd4);
    check_output("exh_retry_err", 32'(retry_err1), 32'd1);

    // Handshake hold with ack low on index 1.
    $display("[TB] handshake hold");
    default_set = 16'h379C;
    bus1.ack = 1'b0;
    push_exp(1, 16'h379C);
    apply_stimulus(1);
    check_output("hs_retry_err_cleared", 32'(retry_err1), 32'd0);
    wait_valid1("hs_first_valid");
    bus1.ack = 1'b1;
    tick(1);
    bus1.ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_output("hs_hold_valid", 32'(bus1.num_valid), 32'd1);
      check_output("hs_hold_idx", 32'(bus1.num_idx), 32'd1);
      check_output("hs_hold_out", 32'(bus1.num_out), 32'd7);
      tick(1);
    end
    bus1.ack = 1'b1;
    tick(1);
    check_output("hs_advance_idx", 32'(bus1.num_idx), 32'd2);
    check_output("hs_advance_out", 32'(bus1.num_out), 32'd9);
    wait_done(1, "hs_done");

    // Multi-round game, then abort during round 2.
    $display("[TB] multi-round");
    bus4.ack = 1'b1;
    for (int r = 0; r < 4; r++) push_exp(4, 16'h1234);
    apply_stimulus(4);
    wait_done(4, "multi_done");
    check_output("multi_round_cnt", 32'(round_cnt4), 32'd4);
    check_output("multi_busy", 32'(busy4), 32'd0);
    push_exp(4, 16'h1234);
    apply_stimulus(4);
    check_output("multi_restart_cnt", 32'(round_cnt4), 32'd0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (round_cnt4 == 3'd1 && bus4.num_valid) begin
        found = 1;
        break;
      end
      tick(1);
    end
    check_output("abort_reach_round2", 32'(found), 32'd1);
    abort4 = 1'b1;
    bus4.ack = 1'b0;
    tick(1);
    abort4 = 1'b0;
    check_output("abort_valid", 32'(bus4.num_valid), 32'd0);
    check_output("abort_busy", 32'(busy4), 32'd0);
    check_output("abort_done", 32'(done4), 32'd0);
    check_output("abort_load", 32'(bus4.load), 32'd0);
    check_output("abort_round_cnt", 32'(round_cnt4), 32'd1);

    // Async reset while presenting.
    $display("[TB] async reset");
    bus1.ack = 1'b0;
    apply_stimulus(1);
    wait_valid1("rst_reach_present");
    #3;
    rst = 1'b0;
    #1;
    check_all_zero1("async_rst");
    tick(2);
    rst = 1'b1;
    tick(1);
    bus1.ack = 1'b1;
    push_exp(1, 16'h379C);
    apply_stimulus(1);
    wait_done(1, "post_rst_done");
    check_output("post_rst_round_cnt", 32'(round_cnt1), 32'd1);
    check_output("post_rst_retry_err", 32'(retry_err1), 32'd0);

    tick(2);
    check_output("exp1_drained", 32'(exp1_q.size()), 32'd0);
    check_output("exp4_drained", 32'(exp4_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
